// File: rtl/sll_seq_if.sv
// Handshake/result bundle for sll_seq; the rotate request wire exists only when SLL_SEQ_ROTATE_EN is defined.
interface sll_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] data;
    logic [31:0]      shiftBits;
`ifdef SLL_SEQ_ROTATE_EN
    logic             rotate;
`endif
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sdata;

`ifdef SLL_SEQ_ROTATE_EN
    modport master (output start, data, shiftBits, rotate, input busy, done, sdata);
    modport slave  (input start, data, shiftBits, rotate, output busy, done, sdata);
`else
    modport master (output start, data, shiftBits, input busy, done, sdata);
    modport slave  (input start, data, shiftBits, output busy, done, sdata);
`endif
endinterface

// File: rtl/sll_seq.sv
// Iterative shift-left (4 bits/cycle while >=4 remain, else 1): done pulses k=n/4+n%4 edges after capture; start is dropped while busy.
// SLL_SEQ_ROTATE_EN adds a rotate-left option captured with start, with identical timing.
module sll_seq #(
    parameter int WIDTH    = 32,
    parameter int SHAMT_W  = 5,
    parameter int BIG_STEP = 4
) (
    input  logic       clk,
    input  logic       rst,
    sll_seq_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [SHAMT_W-1:0] BIG_CNT = SHAMT_W'(BIG_STEP);
    localparam logic [SHAMT_W-1:0] ONE_CNT = SHAMT_W'(1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]   sdata_q, sdata_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   step_big, step_one;
    logic               unused_shift_hi;

    assign unused_shift_hi = ^bus.shiftBits[31:SHAMT_W];

`ifdef SLL_SEQ_ROTATE_EN
    logic rot_q, rot_d;
`endif

    // Both step widths are computed every cycle; the count picks one.
    always_comb begin
        step_big = acc_q << BIG_STEP;
        step_one = acc_q << 1;
`ifdef SLL_SEQ_ROTATE_EN
        if (rot_q) begin
            step_big = (acc_q << BIG_STEP) | (acc_q >> (WIDTH - BIG_STEP));
            step_one = (acc_q << 1) | (acc_q >> (WIDTH - 1));
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sdata_d = sdata_q;
`ifdef SLL_SEQ_ROTATE_EN
        rot_d   = rot_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    acc_d = bus.data;
                    cnt_d = bus.shiftBits[SHAMT_W-1:0];
`ifdef SLL_SEQ_ROTATE_EN
                    rot_d = bus.rotate;
`endif
                    if (cnt_d == '0) begin
                        state_d = DONE;
                        sdata_d = bus.data;
                    end else begin
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                if (cnt_q >= BIG_CNT) begin
                    acc_d = step_big;
                    cnt_d = cnt_q - BIG_CNT;
                end else begin
                    acc_d = step_one;
                    cnt_d = cnt_q - ONE_CNT;
                end
                if (cnt_d == '0) begin
                    state_d = DONE;
                    sdata_d = acc_d;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SLL_SEQ_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sdata_q <= sdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef SLL_SEQ_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sdata = sdata_q;
endmodule

// File: doc/sll_seq.md
Name: sll_seq

Overview:
- Multi-cycle shift-left-logical unit for the miniRV execute stage; complements the combinational arithmetic right shifter.
- Accepts an operand and shift amount with a start pulse and shifts iteratively, 4 bits per cycle while at least 4 remain, otherwise 1 bit per cycle.
- Presents the result with a one-cycle done pulse and holds it until the next accepted start.

Parameters:
- WIDTH, 32, operand/result width.
- SHAMT_W, 5, number of low shiftBits bits used as the shift amount.
- BIG_STEP, 4, coarse step size; must be a power of 2 and less than WIDTH.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- data  input  WIDTH  operand.
- shiftBits  input  32  shift amount; only [SHAMT_W-1:0] is used, upper bits are ignored.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; sdata is valid.
- sdata  output  WIDTH  registered result, held after done.

Behaviour:
- Reset is asynchronous, active-high, one clock.
  - Reset values: state=IDLE, acc=0, cnt=0, busy=0, done=0, sdata=0.
  - Asserting rst mid-operation aborts immediately; no done pulse is produced for the aborted request.
- States: IDLE, SHIFT, DONE. busy = (state != IDLE); done = (state == DONE).
- IDLE, with start=1 at edge T:
  - acc <= data; cnt <= shiftBits[SHAMT_W-1:0].
  - If cnt is 0, go to DONE with sdata <= data; otherwise go to SHIFT.
- SHIFT, each edge:
  - If cnt >= BIG_STEP: acc <= acc << BIG_STEP; cnt -= BIG_STEP.
  - Else: acc <= acc << 1; cnt -= 1.
  - Zeros fill from the LSB; bits leaving the MSB are discarded.
  - When the new cnt is 0: go to DONE and load sdata with the new acc value.
- DONE: lasts exactly one cycle, then returns unconditionally to IDLE. start is ignored in this cycle.
- Latency: with n = shamt and k = n/4 + n%4, done is high in the cycle following edge T+k.
  - n=0 gives k=0 (done in the cycle right after the capture edge).
  - n=31 gives k=10 (7 coarse steps plus 3 single steps).
- sdata changes only on entry to DONE or on reset, and is stable from the done pulse until the next result.
- start while busy (SHIFT or DONE) is ignored and not queued. data and shiftBits are don't-care after capture.
- Back-to-back: start is accepted in the IDLE cycle that follows DONE, so minimum issue interval is k+2 cycles.

Optional Feature:
- Macro SLL_SEQ_ROTATE_EN.
- When defined:
  - Adds input port rotate (1 bit), captured with start.
  - If the captured rotate=1, bits leaving the MSB re-enter at the LSB (rotate-left) in both step sizes.
  - Timing is identical to the plain shift.
- When undefined:
  - No rotate port exists; zero-fill behaviour only.

Test Plan:
- Reset: assert rst mid-SHIFT with data=32'hFFFFFFFF, shamt=20 -> busy=0, done=0, sdata=0 immediately; no done pulse after rst is released.
- Zero shift: data=32'h8000_0001, shiftBits=0 -> done high in the cycle after the capture edge, sdata=32'h8000_0001.
- Mixed steps: data=32'h0000_0001, shiftBits=7 -> busy high for 5 cycles, done after 4 SHIFT edges, sdata=32'h0000_0080.
- Max shift, upper bits ignored: data=32'hFFFF_FFFF, shiftBits=32'hFFFF_FFFF (shamt=31) -> k=10, sdata=32'h8000_0000.
- Busy/handshake: start pulsed during SHIFT and during DONE -> ignored, sdata unchanged. Back-to-back: new start in the IDLE cycle after DONE with data=32'h3, shamt=4 -> sdata=32'h30 after 1 SHIFT edge.
- SLL_SEQ_ROTATE_EN defined: data=32'h8000_0001, shamt=5, rotate=1 -> sdata=32'h0000_0030. Same stimulus with rotate=0 -> sdata=32'h0000_0020.
